// File: rtl/app_ser_pkg.sv
// app_ser_pkg: shared state encoding, header default and frame length helper
package app_ser_pkg;
  typedef enum logic [2:0] {IDLE, REQ, LOAD, SHIFT, GAP} state_t;
  localparam logic [3:0] HEADER_DEFAULT = 4'b1010;
  function automatic int frame_len(input int word_width, input int hdr_width);
    return hdr_width + word_width + 1;
  endfunction
endpackage

// File: rtl/ser_piso.sv
// ser_piso: parallel-load, MSB-first shift register; zeros shift in so the line idles low
module ser_piso #(
  parameter int W = 21
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] q;
  // load wins over shift; after W shifts the register is empty again
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[W-2:0], 1'b0};
  assign msb = q[W-1];
endmodule

// File: rtl/tstamp_serializer.sv
// tstamp_serializer: drains the timestamp FIFO and sends each word as a framed serial bitstream
module tstamp_serializer
  import app_ser_pkg::*;
#(
  parameter int                  WORDWIDTH  = 16,
  parameter int                  HDR_WIDTH  = 4,
  parameter logic [HDR_WIDTH-1:0] HEADER    = HEADER_DEFAULT,
  parameter int                  GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 fifo_empty_i,
  input  logic [WORDWIDTH-1:0] fifo_data_i,
  output logic                 fifo_re_o,
  output logic                 ser_o,
  output logic                 frame_o,
  output logic                 busy_o,
  output logic [15:0]          frame_cnt_o
);
  localparam int FRAME_LEN = frame_len(WORDWIDTH, HDR_WIDTH);
  localparam int CW = $clog2(FRAME_LEN);
  state_t         state;
  logic [CW-1:0]  bit_cnt;
  logic [3:0]     gap_cnt;
  assign fifo_re_o = state == REQ;
  assign busy_o    = state != IDLE;
  ser_piso #(.W(FRAME_LEN)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (state == LOAD),
    .shift (state == SHIFT),
    .din   ({HEADER, fifo_data_i, ^fifo_data_i}),
    .msb   (ser_o)
  );
  // frame sequencing: request, capture, shift out FRAME_LEN bits, then hold the idle gap
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frame_o     <= 1'b0;
      frame_cnt_o <= '0;
    end else
      case (state)
        IDLE:  if (enable_i && !fifo_empty_i) state <= REQ;
        REQ:   state <= LOAD;
        LOAD: begin
          bit_cnt <= CW'(FRAME_LEN - 1);
          frame_o <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT:
          if (bit_cnt == '0) begin
            state       <= GAP;
            frame_o     <= 1'b0;
            frame_cnt_o <= frame_cnt_o + 16'd1;
            gap_cnt     <= 4'(GAP_CYCLES - 1);
          end else bit_cnt <= bit_cnt - CW'(1);
        GAP:
          if (gap_cnt == 4'd0) state <= IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_tstamp_serializer.sv
// tb_tstamp_serializer: randomized and directed checks against a frame-schedule reference model
module tb_tstamp_serializer;
  logic        clk = 1'b0;
  logic        rst, enable_i, fifo_empty_i;
  logic [15:0] fifo_data_i;
  logic        fifo_re_o, ser_o, frame_o, busy_o;
  logic [15:0] frame_cnt_o;
  int          compared = 0, mismatched = 0;
  logic [15:0] q[$];
  int          cyc = 0, start = -1, re_seen = 0;
  logic [20:0] bits;
  logic [15:0] cnt_m = 16'd0;

  tstamp_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_re_o    (fifo_re_o),
    .ser_o        (ser_o),
    .frame_o      (frame_o),
    .busy_o       (busy_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  // A frame decided at cycle s: read strobe at s+1, bits at s+3..s+23,
  // count bumps from s+24, busy through s+25, next decision at s+26.
  task automatic step();
    int   d;
    logic re_e, fr_e, ser_e, busy_e, re_now;
    @(negedge clk);
    d = (start < 0) ? -1 : cyc - start;
    if (d == 26) begin
      start = -1;
      d = -1;
    end
    if (d == 24) cnt_m++;
    re_e   = d == 1;
    fr_e   = d >= 3 && d <= 23;
    ser_e  = fr_e ? bits[23-d] : 1'b0;
    busy_e = d >= 1 && d <= 25;
    chk("fifo_re", 16'(fifo_re_o), 16'(re_e));
    chk("frame", 16'(frame_o), 16'(fr_e));
    chk("ser", 16'(ser_o), 16'(ser_e));
    chk("busy", 16'(busy_o), 16'(busy_e));
    chk("frame_cnt", frame_cnt_o, cnt_m);
    re_now = fifo_re_o;
    if (re_now) re_seen++;
    if (start < 0 && !rst && enable_i && q.size() > 0) begin
      start = cyc;
      bits  = {4'b1010, q[0], ^q[0]};
    end
    @(posedge clk);
    #1;
    if (re_now && q.size() > 0) fifo_data_i = q.pop_front();
    fifo_empty_i = q.size() == 0;
    cyc++;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_re"}, 16'(fifo_re_o), 16'd0);
    chk({tag, "_ser"}, 16'(ser_o), 16'd0);
    chk({tag, "_frame"}, 16'(frame_o), 16'd0);
    chk({tag, "_busy"}, 16'(busy_o), 16'd0);
    chk({tag, "_cnt"}, frame_cnt_o, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    repeat (3) step();
    // single word, 16'h5555
    enable_i = 1'b1;
    re_seen = 0;
    push(16'h5555);
    repeat (30) step();
    chk("one_re_pulse", 16'(re_seen), 16'd1);
    chk("cnt_after_one", frame_cnt_o, 16'd1);
    // parity edge cases
    push(16'h0001);
    repeat (27) step();
    push(16'hFFFF);
    repeat (27) step();
    // three queued words back to back
    re_seen = 0;
    push(16'h1234);
    push(16'hABCD);
    push(16'h0000);
    repeat (26 * 3 + 10) step();
    chk("three_re_pulses", 16'(re_seen), 16'd3);
    chk("cnt_after_three", frame_cnt_o, 16'd6);
    // enable dropped mid-frame with FIFO non-empty
    push(16'hC0DE);
    push(16'hBEEF);
    repeat (10) step();
    enable_i = 1'b0;
    re_seen = 0;
    repeat (50) step();
    chk("no_re_while_disabled", 16'(re_seen), 16'd0);
    enable_i = 1'b1;
    repeat (30) step();
    // reset in the middle of SHIFT
    push(16'h7E57);
    repeat (12) step();
    rst = 1'b1;
    #1;
    reset_checks("midreset");
    start = -1;
    cnt_m = 16'd0;
    repeat (2) step();
    rst = 1'b0;
    push(16'h0F0F);
    repeat (30) step();
    chk("cnt_after_reset_frame", frame_cnt_o, 16'd1);
    // counter wrap
    force dut.frame_cnt_o = 16'hFFFF;
    cnt_m = 16'hFFFF;
    step();
    release dut.frame_cnt_o;
    step();
    push(16'h2468);
    repeat (30) step();
    chk("cnt_wrap", frame_cnt_o, 16'h0000);
    // randomized traffic
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) != 0) push(16'($urandom));
      enable_i = $urandom_range(0, 3) != 0;
      repeat ($urandom_range(1, 40)) step();
    end
    enable_i = 1'b1;
    repeat (26 * (q.size() + 1) + 5) step();
    chk("fifo_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
